// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the fetch-stage program counter
package pc_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

    // Kind of redirect selected (or latched) for the next pc
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_EXC  = 2'd2
    } redir_kind_e;

    localparam logic [31:0] PC_DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] PC_DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int          PC_DEF_STEP         = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - redirect priority selection and pending-redirect latch
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int             N          = 32,
    parameter logic [N-1:0]   EXC_VECTOR = N'(PC_DEF_EXC_VECTOR)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         active,
    input  logic         stall,
    input  logic         exc,
    input  logic         br_taken,
    input  logic [N-1:0] br_target,
    output redir_kind_e  sel_kind,
    output logic [N-1:0] sel_target,
    output logic         redirect_pend
);

    redir_kind_e  pend_kind_q;
    logic [N-1:0] pend_target_q;

    // Capture redirects raised while stalled; an exception is sticky over any later branch.
    // With stall low every latched entry is being applied this cycle, so the latch empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_kind_q   <= RD_NONE;
            pend_target_q <= '0;
        end else if (active) begin
            if (stall) begin
                if (exc) begin
                    pend_kind_q <= RD_EXC;
                end else if (br_taken && (pend_kind_q != RD_EXC)) begin
                    pend_kind_q   <= RD_BR;
                    pend_target_q <= br_target;
                end
            end else begin
                pend_kind_q <= RD_NONE;
            end
        end
    end

    // Priority: new exc, pending exc, new branch, pending branch
    always_comb begin
        sel_kind   = RD_NONE;
        sel_target = pend_target_q;
        if (exc || (pend_kind_q == RD_EXC)) begin
            sel_kind   = RD_EXC;
            sel_target = EXC_VECTOR;
        end else if (br_taken) begin
            sel_kind   = RD_BR;
            sel_target = br_target;
        end else if (pend_kind_q == RD_BR) begin
            sel_kind   = RD_BR;
            sel_target = pend_target_q;
        end
    end

    assign redirect_pend = (pend_kind_q != RD_NONE);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch-stage pc unit with handshake and prioritised redirects; option PC_ALIGN_CHECK_EN
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(PC_DEF_RESET_VECTOR),
    parameter logic [N-1:0] EXC_VECTOR   = N'(PC_DEF_EXC_VECTOR),
    parameter int           STEP         = PC_DEF_STEP
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         exc,
    input  logic         br_taken,
    input  logic [N-1:0] br_target,
    input  logic         imem_ready,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus,
    output logic         fetch_valid,
    output logic         redirect_pend,
    output logic         misalign_err
);

    pc_state_e    state_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;
    logic         fetch_valid_q;
    logic         misalign_q;
    logic         misalign_d;
    logic [N-1:0] target_fix;

    redir_kind_e  sel_kind;
    logic [N-1:0] sel_target;

    pc_redirect_arb #(
        .N          (N),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .active        (state_q != ST_BOOT),
        .stall         (stall),
        .exc           (exc),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .sel_kind      (sel_kind),
        .sel_target    (sel_target),
        .redirect_pend (redirect_pend)
    );

    assign pc_plus = pc_q + N'(STEP);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [N-1:0] ALIGN_MASK = ~(N'(STEP) - N'(1));

    // Branch targets get their sub-step bits cleared; the exception vector is trusted
    always_comb begin
        target_fix = sel_target;
        misalign_d = 1'b0;
        if (sel_kind == RD_BR) begin
            target_fix = sel_target & ALIGN_MASK;
            misalign_d = ((sel_target & ~ALIGN_MASK) != '0);
        end
    end
`else
    assign target_fix = sel_target;
    assign misalign_d = 1'b0;
`endif

    // Next pc when unstalled: redirect first, then sequential advance (RUN only), else hold
    always_comb begin
        pc_d = pc_q;
        if (sel_kind != RD_NONE) begin
            pc_d = target_fix;
        end else if ((state_q == ST_RUN) && imem_ready) begin
            pc_d = pc_plus;
        end
    end

    // Control FSM with registered pc, fetch_valid and misalign pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q       <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                    misalign_q    <= 1'b0;
                end
                ST_RUN, ST_HOLD: begin
                    if (stall) begin
                        state_q       <= ST_HOLD;
                        fetch_valid_q <= 1'b0;
                        misalign_q    <= 1'b0;
                    end else begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                        pc_q          <= pc_d;
                        misalign_q    <= misalign_d;
                    end
                end
                default: begin
                    state_q       <= ST_BOOT;
                    fetch_valid_q <= 1'b0;
                    misalign_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign fetch_valid  = fetch_valid_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        exc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic        redirect_pend;
    logic        misalign_err;

    logic [7:0]  pc8;
    logic [7:0]  pc_plus8;
    logic        fetch_valid8;
    logic        redirect_pend8;
    logic        misalign_err8;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .exc           (exc),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .fetch_valid   (fetch_valid),
        .redirect_pend (redirect_pend),
        .misalign_err  (misalign_err)
    );

    pc_fetch_ctrl #(
        .N            (8),
        .RESET_VECTOR (8'hF4),
        .EXC_VECTOR   (8'h80),
        .STEP         (4)
    ) dut8 (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .exc           (exc),
        .br_taken      (br_taken),
        .br_target     (br_target[7:0]),
        .imem_ready    (imem_ready),
        .pc            (pc8),
        .pc_plus       (pc_plus8),
        .fetch_valid   (fetch_valid8),
        .redirect_pend (redirect_pend8),
        .misalign_err  (misalign_err8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; exc = 1'b0; br_taken = 1'b0;
        br_target = 32'h0; imem_ready = 1'b1;
        step(); step();
        checks++; if (pc !== 32'h0040_0000) $display("FAIL reset_pc got %h want %h", pc, 32'h0040_0000); else passed++;
        checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_fv got %b want 0", fetch_valid); else passed++;
        checks++; if (redirect_pend !== 1'b0) $display("FAIL reset_pend got %b want 0", redirect_pend); else passed++;
        checks++; if (misalign_err !== 1'b0) $display("FAIL reset_mis got %b want 0", misalign_err); else passed++;
        reset = 1'b0;
        step();
        checks++; if (pc !== 32'h0040_0000 || fetch_valid !== 1'b1) $display("FAIL run_first got pc=%h fv=%b want 00400000/1", pc, fetch_valid); else passed++;
        checks++; if (pc8 !== 8'hF4) $display("FAIL run_first8 got %h want f4", pc8); else passed++;
        step();
        checks++; if (pc !== 32'h0040_0004) $display("FAIL advance1 got %h want 00400004", pc); else passed++;
        step();
        checks++; if (pc !== 32'h0040_0008) $display("FAIL advance2 got %h want 00400008", pc); else passed++;
        checks++; if (pc8 !== 8'hFC || pc_plus8 !== 8'h00) $display("FAIL wrap_plus8 got pc=%h plus=%h want fc/00", pc8, pc_plus8); else passed++;
        step();
        checks++; if (pc8 !== 8'h00 || fetch_valid8 !== 1'b1) $display("FAIL wrap8 got pc=%h fv=%b want 00/1", pc8, fetch_valid8); else passed++;
        step();
        checks++; if (pc !== 32'h0040_0010) $display("FAIL advance4 got %h want 00400010", pc); else passed++;
    endtask

    task automatic test_stall_branch();
        stall = 1'b1;
        step();
        checks++; if (pc !== 32'h0040_0010 || fetch_valid !== 1'b0) $display("FAIL stall1 got pc=%h fv=%b want 00400010/0", pc, fetch_valid); else passed++;
        br_taken = 1'b1; br_target = 32'h0040_0100;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 32'h0040_0010 || redirect_pend !== 1'b1) $display("FAIL stall2 got pc=%h pend=%b want 00400010/1", pc, redirect_pend); else passed++;
        step();
        checks++; if (pc !== 32'h0040_0010 || redirect_pend !== 1'b1) $display("FAIL stall3 got pc=%h pend=%b want 00400010/1", pc, redirect_pend); else passed++;
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h0040_0100 || redirect_pend !== 1'b0 || fetch_valid !== 1'b1) $display("FAIL stall_release got pc=%h pend=%b fv=%b want 00400100/0/1", pc, redirect_pend, fetch_valid); else passed++;
    endtask

    task automatic test_pending_exc();
        stall = 1'b1; exc = 1'b1;
        step();
        exc = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0200;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 32'h0040_0100 || redirect_pend !== 1'b1) $display("FAIL exc_pend got pc=%h pend=%b want 00400100/1", pc, redirect_pend); else passed++;
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h8000_0180 || redirect_pend !== 1'b0) $display("FAIL exc_release got pc=%h pend=%b want 80000180/0", pc, redirect_pend); else passed++;
    endtask

    task automatic test_same_cycle();
        br_taken = 1'b1; br_target = 32'h0040_0020;
        step();
        checks++; if (pc !== 32'h0040_0020) $display("FAIL br_run got %h want 00400020", pc); else passed++;
        exc = 1'b1; br_target = 32'h0040_0300;
        step();
        exc = 1'b0;
        checks++; if (pc !== 32'h8000_0180) $display("FAIL exc_over_br got %h want 80000180", pc); else passed++;
        br_target = 32'h0040_0020;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 32'h0040_0020) $display("FAIL br_back got %h want 00400020", pc); else passed++;
    endtask

    task automatic test_imem_wait();
        imem_ready = 1'b0;
        step();
        checks++; if (pc !== 32'h0040_0020 || fetch_valid !== 1'b1) $display("FAIL imem_wait1 got pc=%h fv=%b want 00400020/1", pc, fetch_valid); else passed++;
        step();
        checks++; if (pc !== 32'h0040_0020) $display("FAIL imem_wait2 got %h want 00400020", pc); else passed++;
        br_taken = 1'b1; br_target = 32'h0040_0300;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 32'h0040_0300) $display("FAIL br_no_ready got %h want 00400300", pc); else passed++;
        step();
        checks++; if (pc !== 32'h0040_0300) $display("FAIL hold_after_br got %h want 00400300", pc); else passed++;
        imem_ready = 1'b1;
        step();
        checks++; if (pc !== 32'h0040_0304) $display("FAIL resume got %h want 00400304", pc); else passed++;
    endtask

    task automatic test_misalign();
        br_taken = 1'b1; br_target = 32'h0040_0106;
        step();
        br_taken = 1'b0; imem_ready = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        checks++; if (pc !== 32'h0040_0104 || misalign_err !== 1'b1) $display("FAIL misalign got pc=%h err=%b want 00400104/1", pc, misalign_err); else passed++;
`else
        checks++; if (pc !== 32'h0040_0106 || misalign_err !== 1'b0) $display("FAIL misalign got pc=%h err=%b want 00400106/0", pc, misalign_err); else passed++;
`endif
        step();
        checks++; if (misalign_err !== 1'b0) $display("FAIL misalign_pulse got %b want 0", misalign_err); else passed++;
        exc = 1'b1;
        step();
        exc = 1'b0;
        checks++; if (pc !== 32'h8000_0180 || misalign_err !== 1'b0) $display("FAIL exc_no_mis got pc=%h err=%b want 80000180/0", pc, misalign_err); else passed++;
        imem_ready = 1'b1;
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h0040_0500;
        step();
        br_taken = 1'b0;
        step();
        checks++; if (redirect_pend !== 1'b1) $display("FAIL hold_pend got %b want 1", redirect_pend); else passed++;
        reset = 1'b1;
        step();
        checks++; if (pc !== 32'h0040_0000 || redirect_pend !== 1'b0 || fetch_valid !== 1'b0) $display("FAIL reset_hold got pc=%h pend=%b fv=%b want 00400000/0/0", pc, redirect_pend, fetch_valid); else passed++;
        reset = 1'b0; stall = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0700;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 32'h0040_0000 || fetch_valid !== 1'b1) $display("FAIL boot_ignore got pc=%h fv=%b want 00400000/1", pc, fetch_valid); else passed++;
        step();
        checks++; if (pc !== 32'h0040_0004 || redirect_pend !== 1'b0) $display("FAIL latch_discard got pc=%h pend=%b want 00400004/0", pc, redirect_pend); else passed++;
    endtask

    initial begin
        test_reset();
        test_stall_branch();
        test_pending_exc();
        test_same_cycle();
        test_imem_wait();
        test_misalign();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Parametrised program-counter unit for the pipelined core's fetch stage. It is the next generation of the plain PC register. It adds a configurable width, reset vector and step, and a fetch handshake toward instruction memory. It also adds prioritised redirects (exception over branch/jump) and a pending-redirect latch, so a redirect raised during a hazard stall is never lost. It sits between the hazard/branch units and instruction memory, feeding the IF/ID pipeline register.

## Interface
- N, 32, PC width in bits
- RESET_VECTOR, 32'h0040_0000, PC value loaded by reset
- EXC_VECTOR, 32'h8000_0180, exception handler address
- STEP, 4, sequential increment; must be a power of two ≥1
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- stall  in  1  hazard-unit hold request
- exc  in  1  exception redirect request (target EXC_VECTOR)
- br_taken  in  1  branch/jump redirect request
- br_target  in  N  branch/jump target, valid with br_taken
- imem_ready  in  1  instruction memory accepts the current fetch
- pc  out  N  current fetch address
- pc_plus  out  N  pc + STEP (combinational, modulo 2^N)
- fetch_valid  out  1  pc is a valid fetch request
- redirect_pend  out  1  a redirect is latched and awaiting stall release
- misalign_err  out  1  misaligned redirect flagged (see Configuration)

## Operation
- FSM states: BOOT, RUN, HOLD.
- On reset: state=BOOT, pc=RESET_VECTOR, fetch_valid=0, redirect_pend=0, pending latch cleared, misalign_err=0.
- BOOT→RUN unconditionally on the next cycle. All requests in BOOT are ignored and pc holds.
- RUN→HOLD when stall=1. HOLD→RUN when stall=0.
- fetch_valid=1 only in RUN.
- Next-pc selection in RUN with stall=0, highest priority first:
  - new exc → EXC_VECTOR
  - pending exc → EXC_VECTOR
  - new br_taken → br_target
  - pending br → pending target
  - imem_ready=1 → pc_plus
  - else hold.
- A redirect applies regardless of imem_ready. Applying any redirect clears the pending latch.
- Pending latch (written when stall=1, in RUN or HOLD):
  - exc sets pending exc.
  - br_taken stores the target only if no exc is pending; a later br overwrites an earlier pending br.
  - A pending exc is never overwritten by a br.
- redirect_pend=1 whenever the latch holds an entry.
- The pending latch is cleared on leaving HOLD only when a redirect is applied.
- With stall=1, pc holds regardless of other inputs.
- Arithmetic is modulo 2^N: pc=2^N−STEP advancing gives pc=0, with no flag.
- Reset during HOLD with a pending redirect: the latch is discarded and pc=RESET_VECTOR.

## Timing
- All state and outputs are registered on the clk rising edge; pc_plus is the only combinational output.
- Redirect latency: request in cycle t (stall=0, RUN) → pc=target in cycle t+1.
- Pending redirect: stall drops in cycle t → pc=target in cycle t+1.
- After reset deasserts: BOOT for 1 cycle. fetch_valid rises on the 2nd cycle after reset deasserts, with pc=RESET_VECTOR.
- Throughput: one pc advance per cycle while imem_ready=1 and stall=0.

## Configuration
- Macro PC_ALIGN_CHECK_EN.
- Defined: a redirect target with nonzero low log2(STEP) bits is applied with those bits cleared. misalign_err pulses high for exactly the cycle in which the corrected pc appears.
- Undefined: targets are applied verbatim and misalign_err is tied 0.
- EXC_VECTOR and RESET_VECTOR are never checked.

## Structure
- Package pc_pkg:
  - state enum typedef (BOOT/RUN/HOLD)
  - redirect-kind typedef (NONE/BR/EXC)
  - default vector constants.
- One sub-module, pc_redirect_arb: priority selection plus the pending latch. It outputs the selected kind and target; the top module owns the FSM and pc register.

## Test plan
- Reset then release, imem_ready=1 → pc=0x0040_0000 with fetch_valid=0 for 1 cycle, then 0x0040_0000, 0x0040_0004, 0x0040_0008 with fetch_valid=1.
- pc=0x0040_0010, stall=1 for 3 cycles, br_taken=1 target 0x0040_0100 in the 2nd stall cycle → pc holds and redirect_pend=1; stall drops → pc=0x0040_0100, redirect_pend=0.
- During stall: exc, then a later br_taken to 0x0040_0200 → after release pc=0x8000_0180 (pending exc not overwritten).
- exc and br_taken in the same RUN cycle → pc=0x8000_0180.
- imem_ready=0 for 2 cycles at pc=0x0040_0020 → pc holds; br_taken to 0x0040_0300 with imem_ready=0 → pc=0x0040_0300 next cycle.
- N=8, STEP=4, pc=0xFC advancing → pc=0x00. With PC_ALIGN_CHECK_EN, br_target=0x0040_0106 → pc=0x0040_0104 and misalign_err=1 for one cycle.
